// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one external memory bus between the I-cache refill
// port (m0) and the D-cache port (m1). One outstanding transaction at a time;
// the owner keeps the bus until its last read beat or write ack.
// Build option: RISCV_MEM_ARB_RR_EN selects round-robin arbitration; without it
// m1 has fixed priority with a starvation escape for m0.
module riscv_mem_arbiter #(
    parameter int unsigned LEN_W        = 3,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             m0_req,
    input  logic [31:0]      m0_addr,
    input  logic             m0_we,
    input  logic [3:0]       m0_wstrb,
    input  logic [31:0]      m0_wdata,
    input  logic [LEN_W-1:0] m0_len,
    output logic             m0_accept,
    output logic             m0_rvalid,
    output logic [31:0]      m0_rdata,
    output logic             m0_done,
    input  logic             m1_req,
    input  logic [31:0]      m1_addr,
    input  logic             m1_we,
    input  logic [3:0]       m1_wstrb,
    input  logic [31:0]      m1_wdata,
    input  logic [LEN_W-1:0] m1_len,
    output logic             m1_accept,
    output logic             m1_rvalid,
    output logic [31:0]      m1_rdata,
    output logic             m1_done,
    output logic             bus_req,
    output logic [31:0]      bus_addr,
    output logic             bus_we,
    output logic [3:0]       bus_wstrb,
    output logic [31:0]      bus_wdata,
    output logic [LEN_W-1:0] bus_len,
    input  logic             bus_accept,
    input  logic             bus_rvalid,
    input  logic [31:0]      bus_rdata,
    input  logic             bus_wack,
    output logic             err_unexp
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;       // 0 = m0, 1 = m1
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              err_q, err_d;

    logic any_req;
    logic grant;
    logic win;                                 // winner of this IDLE cycle, 1 = m1

    assign any_req = m0_req | m1_req;
    assign grant   = (state_q == StIdle) && any_req;

`ifdef RISCV_MEM_ARB_RR_EN
    logic rr_last_q, rr_last_d;

    // Tie goes to whichever master was not granted last.
    always_comb begin
        win       = m1_req && (!m0_req || !rr_last_q);
        rr_last_d = grant ? win : rr_last_q;
    end

    // Round-robin history register.
    always_ff @(posedge clk) begin
        if (srst) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`else
    localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

    logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;

    // m1 wins ties unless m0 has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        win          = m1_req && (!m0_req || (starve_cnt_q != StarveMax));
        starve_cnt_d = starve_cnt_q;
        if (!m0_req) begin
            starve_cnt_d = '0;
        end else if (grant) begin
            starve_cnt_d = win ? (starve_cnt_q + StarveW'(1)) : '0;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (srst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    // Latched attributes of the granted master drive the bus directly.
    assign bus_req   = (state_q == StReq);
    assign bus_addr  = addr_q;
    assign bus_we    = we_q;
    assign bus_wstrb = wstrb_q;
    assign bus_wdata = wdata_q;
    assign bus_len   = len_q;
    assign err_unexp = err_q;

    // Transaction sequencing: next state, attribute latch and per-master outputs.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        m0_accept  = 1'b0;
        m1_accept  = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        m0_done    = 1'b0;
        m1_done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Responses with nothing outstanding are dropped but flagged.
                if (bus_rvalid || bus_wack) begin
                    err_d = 1'b1;
                end
                if (any_req) begin
                    owner_d = win;
                    addr_d  = win ? m1_addr  : m0_addr;
                    we_d    = win ? m1_we    : m0_we;
                    wstrb_d = win ? m1_wstrb : m0_wstrb;
                    wdata_d = win ? m1_wdata : m0_wdata;
                    len_d   = win ? m1_len   : m0_len;
                    state_d = StReq;
                end
            end
            StReq: begin
                // A beat arriving with the accept is not counted.
                if (bus_rvalid || bus_wack) begin
                    err_d = 1'b1;
                end
                if (bus_accept) begin
                    m0_accept  = !owner_q;
                    m1_accept  = owner_q;
                    beat_cnt_d = '0;
                    state_d    = StResp;
                end
            end
            StResp: begin
                if (we_q) begin
                    if (bus_rvalid) begin
                        err_d = 1'b1;
                    end
                    if (bus_wack) begin
                        m0_done = !owner_q;
                        m1_done = owner_q;
                        state_d = StIdle;
                    end
                end else begin
                    m0_rdata = owner_q ? '0 : bus_rdata;
                    m1_rdata = owner_q ? bus_rdata : '0;
                    if (bus_rvalid) begin
                        m0_rvalid  = !owner_q;
                        m1_rvalid  = owner_q;
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                        // Compare before increment so len = all-ones gives 2**LEN_W beats.
                        if (beat_cnt_q == len_q) begin
                            m0_done = !owner_q;
                            m1_done = owner_q;
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and attribute registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule
